// File: rtl/vec_load_streamer_if.sv
// Bundle for vec_load_streamer: command, memory read port, output stream and status.
// With VLS_PERF_CNT_EN defined the bundle also carries the o_stall_cnt counter.
interface vec_load_streamer_if #(
    parameter int ADDR_W = 12,
    parameter int SIZE   = 32,
    parameter int LEN_W  = 13
) ();
    // Handshake: a command is accepted on a rising edge where i_cmd_valid && o_cmd_ready;
    // a stream beat moves on a rising edge where o_valid && i_ready, and o_data/o_last
    // stay unchanged while o_valid && !i_ready.
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [ADDR_W-1:0] i_cmd_base;
    logic [ADDR_W-1:0] i_cmd_stride;
    logic [LEN_W-1:0]  i_cmd_len;
    logic              i_abort;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [SIZE-1:0]   i_mem_data;
    logic [SIZE-1:0]   o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_last;
    logic              o_busy;
    logic              o_done;
    logic [1:0]        o_state;
`ifdef VLS_PERF_CNT_EN
    logic [31:0]       o_stall_cnt;
`endif

    modport master (
`ifdef VLS_PERF_CNT_EN
        output o_stall_cnt,
`endif
        input  i_cmd_valid, i_cmd_base, i_cmd_stride, i_cmd_len, i_abort,
        input  i_mem_data, i_ready,
        output o_cmd_ready, o_mem_addr, o_data, o_valid, o_last,
        output o_busy, o_done, o_state
    );

    modport slave (
`ifdef VLS_PERF_CNT_EN
        input  o_stall_cnt,
`endif
        output i_cmd_valid, i_cmd_base, i_cmd_stride, i_cmd_len, i_abort,
        output i_mem_data, i_ready,
        input  o_cmd_ready, o_mem_addr, o_data, o_valid, o_last,
        input  o_busy, o_done, o_state
    );
endinterface

// File: rtl/vec_load_streamer.sv
// Strided vector load: walks base/stride/len addresses on the memory read port and streams the
// captured words through a 2-entry skid FIFO. Define VLS_PERF_CNT_EN to add the stall counter.
module vec_load_streamer #(
    parameter int ADDR_W = 12,
    parameter int SIZE   = 32,
    parameter int LEN_W  = 13
) (
    input logic                 i_clk,
    input logic                 i_rst,
    vec_load_streamer_if.master bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [LEN_W-1:0] ONE_BEAT = LEN_W'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] stride;
    logic [LEN_W-1:0]  remaining;
    logic [SIZE-1:0]   head_data;
    logic [SIZE-1:0]   tail_data;
    logic              head_last;
    logic              tail_last;
    logic [1:0]        count;
    logic              done_q;

    logic pop;
    logic issue;
    logic accept;
    logic abort_now;
    logic push_last;

    assign pop       = (count != 2'd0) && bus.i_ready;
    // A full FIFO can still take a new word when the head leaves on the same edge.
    assign issue     = (state == ST_RUN) && ((count != 2'd2) || pop);
    assign accept    = bus.o_cmd_ready && bus.i_cmd_valid;
    assign abort_now = bus.i_abort && (state != ST_IDLE);
    assign push_last = (remaining == ONE_BEAT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            cur_addr  <= '0;
            stride    <= '0;
            remaining <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cur_addr  <= bus.i_cmd_base;
                        stride    <= bus.i_cmd_stride;
                        remaining <= bus.i_cmd_len;
                        if (bus.i_cmd_len == '0) done_q <= 1'b1;
                        else                     state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort_now) begin
                        state <= ST_IDLE;
                    end else if (issue) begin
                        cur_addr  <= cur_addr + stride;
                        remaining <= remaining - ONE_BEAT;
                        if (push_last) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (abort_now) begin
                        state <= ST_IDLE;
                    end else if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Skid FIFO: head register drives the stream, tail holds the word behind it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_data <= '0;
            tail_data <= '0;
            head_last <= 1'b0;
            tail_last <= 1'b0;
            count     <= 2'd0;
        end else if (abort_now) begin
            count <= 2'd0;
        end else begin
            case ({issue, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_data <= bus.i_mem_data;
                        head_last <= push_last;
                    end else begin
                        tail_data <= bus.i_mem_data;
                        tail_last <= push_last;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_last <= tail_last;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= bus.i_mem_data;
                        tail_last <= push_last;
                    end else begin
                        head_data <= bus.i_mem_data;
                        head_last <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef VLS_PERF_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (bus.o_valid && !bus.i_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.o_stall_cnt = stall_cnt;
`endif

    assign bus.o_cmd_ready = (state == ST_IDLE) && !i_rst;
    assign bus.o_mem_addr  = cur_addr;
    assign bus.o_data      = head_data;
    assign bus.o_valid     = (count != 2'd0);
    assign bus.o_last      = (count != 2'd0) && head_last;
    assign bus.o_busy      = (state != ST_IDLE);
    assign bus.o_done      = done_q;
    assign bus.o_state     = state;
endmodule

// File: tb/tb_vec_load_streamer.sv
// Directed bench for vec_load_streamer: memory model, command driver, beat scoreboard.
// Stall counter is also checked when built with VLS_PERF_CNT_EN.
module tb_vec_load_streamer;
    localparam int ADDR_W = 12;
    localparam int SIZE   = 32;
    localparam int LEN_W  = 13;

    logic i_clk = 1'b0;
    logic i_rst;

    always #5 i_clk = ~i_clk;

    vec_load_streamer_if #(.ADDR_W(ADDR_W), .SIZE(SIZE), .LEN_W(LEN_W)) bus ();

    vec_load_streamer #(.ADDR_W(ADDR_W), .SIZE(SIZE), .LEN_W(LEN_W)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    logic [SIZE-1:0] mem [4096];
    assign bus.i_mem_data = mem[bus.o_mem_addr];

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int pop_cnt  = 0;
    int stall_seen = 0;

    // Expected beats: {last, data}
    logic [SIZE:0] exp_q[$];
    logic [SIZE:0] exp_beat;
    logic [SIZE:0] prev_beat;
    logic          prev_stall = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard / monitor, sampled on the falling edge
    always @(negedge i_clk) begin
        if (i_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.o_valid)
                chk("stall_stable", {bus.o_last, bus.o_data}, prev_beat);
            if (bus.o_valid && bus.i_ready) begin
                pop_cnt++;
                chk("beat_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_beat = exp_q.pop_front();
                    chk("beat", {bus.o_last, bus.o_data}, exp_beat);
                end
            end
            if (bus.o_valid && !bus.i_ready) stall_seen++;
            prev_stall = bus.o_valid && !bus.i_ready;
            prev_beat  = {bus.o_last, bus.o_data};
            if (bus.o_done) done_cnt++;
        end
    end

    task automatic send_cmd(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                            input logic [LEN_W-1:0] len);
        logic [ADDR_W-1:0] a;
        bit ok;
        @(negedge i_clk);
        bus.i_cmd_valid  = 1'b1;
        bus.i_cmd_base   = base;
        bus.i_cmd_stride = stride;
        bus.i_cmd_len    = len;
        a = base;
        for (int k = 0; k < int'(len); k++) begin
            exp_q.push_back({(k == int'(len) - 1), mem[a]});
            a = a + stride;
        end
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (bus.o_cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
        chk("cmd_accept", ok, 1);
        @(posedge i_clk);
        #1;
        bus.i_cmd_valid = 1'b0;
        stall_seen = 0;
    endtask

    // mode 0: ready high, 1: pattern 1,0,0 repeating, 2: random
    task automatic wait_idle(input int mode);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge i_clk);
            if (!bus.o_busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge i_clk);
            #1;
            case (mode)
                1:       bus.i_ready = ((c % 3) == 2);
                2:       bus.i_ready = 1'($urandom_range(0, 1));
                default: bus.i_ready = 1'b1;
            endcase
        end
        chk("idle_timeout", ok, 1);
        chk("queue_drained", exp_q.size(), 0);
        @(posedge i_clk);
        #1;
        bus.i_ready = 1'b1;
    endtask

    int d0;
    logic [15:0] r16;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            r16 = 16'($urandom_range(0, 65535));
            mem[i] = {r16, 4'hC, i[11:0]};
        end
        i_rst            = 1'b1;
        bus.i_cmd_valid  = 1'b0;
        bus.i_cmd_base   = '0;
        bus.i_cmd_stride = '0;
        bus.i_cmd_len    = '0;
        bus.i_abort      = 1'b0;
        bus.i_ready      = 1'b1;

        // Reset state
        repeat (3) @(negedge i_clk);
        chk("rst_cmd_ready", bus.o_cmd_ready, 0);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_data", bus.o_data, 0);
        chk("rst_addr", bus.o_mem_addr, 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst_cmd_ready", bus.o_cmd_ready, 1);
        chk("post_rst_busy", bus.o_busy, 0);
        chk("post_rst_done", bus.o_done, 0);

        // Basic stream with latency and done timing
        d0 = done_cnt;
        send_cmd(12'h010, 12'h001, 13'd4);
        @(negedge i_clk);
        chk("lat_valid_n1", bus.o_valid, 0);
        chk("lat_busy_n1", bus.o_busy, 1);
        chk("lat_addr_n1", bus.o_mem_addr, 12'h010);
        chk("lat_cmd_ready_n1", bus.o_cmd_ready, 0);
        @(negedge i_clk);
        chk("lat_valid_n2", bus.o_valid, 1);
        chk("lat_data_n2", bus.o_data, mem[12'h010]);
        for (int k = 3; k <= 7; k++) begin
            @(negedge i_clk);
            chk("done_timing", bus.o_done, (k == 6));
        end
        chk("idle_after_done", bus.o_busy, 0);
        wait_idle(0);
        chk("done_once_basic", done_cnt - d0, 1);

        // Address wrap upward, then negative stride across zero
        d0 = done_cnt;
        send_cmd(12'hFFE, 12'h001, 13'd4);
        @(negedge i_clk);
        chk("wrap_first_addr", bus.o_mem_addr, 12'hFFE);
        wait_idle(2);
        send_cmd(12'h001, 12'hFFF, 13'd3);
        wait_idle(0);
        chk("done_wrap", done_cnt - d0, 2);

        // Back-pressure pattern
        d0 = done_cnt;
        send_cmd(12'h100, 12'h004, 13'd8);
        wait_idle(1);
        chk("stalls_seen", (stall_seen != 0), 1);
`ifdef VLS_PERF_CNT_EN
        chk("stall_cnt", bus.o_stall_cnt, stall_seen);
`endif
        chk("done_backpressure", done_cnt - d0, 1);

        // Zero-length command
        d0 = done_cnt;
        send_cmd(12'h005, 12'h001, 13'd0);
        @(negedge i_clk);
        chk("len0_done", bus.o_done, 1);
        chk("len0_valid", bus.o_valid, 0);
        chk("len0_cmd_ready", bus.o_cmd_ready, 1);
        chk("len0_busy", bus.o_busy, 0);
        @(negedge i_clk);
        chk("len0_done_pulse", bus.o_done, 0);
        chk("len0_done_once", done_cnt - d0, 1);

        // Abort after three beats
        d0 = done_cnt;
        send_cmd(12'h200, 12'h003, 13'd10);
        repeat (4) @(negedge i_clk);
        @(posedge i_clk);
        #1;
        chk("abort_beats_left", exp_q.size(), 7);
        bus.i_ready = 1'b0;
        bus.i_abort = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_abort = 1'b0;
        @(negedge i_clk);
        chk("abort_valid", bus.o_valid, 0);
        chk("abort_busy", bus.o_busy, 0);
        chk("abort_done", bus.o_done, 0);
        exp_q.delete();
        bus.i_ready = 1'b1;
        repeat (4) @(negedge i_clk);
        chk("abort_no_done", done_cnt - d0, 0);
        send_cmd(12'h600, 12'h001, 13'd2);
        wait_idle(0);
        chk("after_abort_done", done_cnt - d0, 1);

        // Reset in the middle of a command
        d0 = done_cnt;
        bus.i_ready = 1'b0;
        send_cmd(12'h400, 12'h001, 13'd10);
        repeat (4) @(negedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        chk("midrst_valid", bus.o_valid, 0);
        chk("midrst_busy", bus.o_busy, 0);
        chk("midrst_last", bus.o_last, 0);
        chk("midrst_data", bus.o_data, 0);
        chk("midrst_addr", bus.o_mem_addr, 0);
        chk("midrst_cmd_ready", bus.o_cmd_ready, 0);
        exp_q.delete();
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge i_clk);
        chk("postrst_cmd_ready", bus.o_cmd_ready, 1);
        chk("postrst_valid", bus.o_valid, 0);
        chk("midrst_no_done", done_cnt - d0, 0);
        send_cmd(12'h500, 12'h002, 13'd3);
        wait_idle(0);
        chk("postrst_done", done_cnt - d0, 1);

        // A few random commands under random back-pressure
        for (int n = 0; n < 4; n++) begin
            d0 = done_cnt;
            send_cmd(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                     13'($urandom_range(1, 12)));
            wait_idle(2);
            chk("rand_done", done_cnt - d0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vec_load_streamer.md
Name: vec_load_streamer

Overview:
- Read-side stage directly downstream of the shared vector data memory; owns that memory's combinational read port.
- Accepts one strided-load command (base, stride, length), walks the addresses, captures the asynchronous read data and streams it out over a valid/ready interface to the SIMD lane feeder.
- A 2-entry output skid FIFO sustains 1 word/cycle under back-pressure.

Parameters:
- ADDR_W, 12, memory word-address width; the integrator zero-extends o_mem_addr onto the memory read-address port.
- SIZE, 32, data word width; matches the memory word.
- LEN_W, 13, command length width; allows 0..4096 beats.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid.
- i_cmd_base  in  ADDR_W  first word address.
- i_cmd_stride  in  ADDR_W  address increment, two's complement.
- i_cmd_len  in  LEN_W  number of beats.
- i_abort  in  1  cancel the current command.
- o_mem_addr  out  ADDR_W  memory read address.
- i_mem_data  in  SIZE  memory read data, combinational from o_mem_addr.
- o_data  out  SIZE  stream data (FIFO head).
- o_valid  out  1  stream valid.
- i_ready  in  1  consumer ready.
- o_last  out  1  head beat is the final beat of the command.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle pulse after the final beat is consumed.

Behaviour:
- Reset: state IDLE; o_mem_addr=0; FIFO empty; o_valid=0, o_last=0, o_done=0, o_busy=0; o_data=0. o_cmd_ready=1 once reset deasserts.
- FSM IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid: latch base→cur_addr, stride, len→remaining.
  - len==0 → stay IDLE, pulse o_done next cycle, no beats.
  - Else → RUN.
- FSM RUN:
  - o_cmd_ready=0; o_mem_addr=cur_addr (registered).
  - Issue condition: FIFO not full after this cycle's pop.
  - On issue, the edge pushes {i_mem_data, remaining==1}, cur_addr += stride (mod 2^ADDR_W, wrap silently), remaining -= 1.
  - No issue → o_mem_addr and counters hold.
  - remaining reaching 0 → DRAIN.
- FSM DRAIN: wait until FIFO empty (last beat popped), pulse o_done for 1 cycle, → IDLE.
- Latency: command accepted at edge N; first read issued during cycle N+1; o_valid high from cycle N+2. Steady state is 1 beat/cycle while i_ready=1.
- Handshake:
  - Beat transfers when o_valid && i_ready.
  - o_data/o_last are stable while o_valid && !i_ready.
  - Simultaneous push and pop on a full FIFO is permitted.
- Memory coherence: a same-cycle write to the address being read returns the pre-write value (write lands on the edge). This is required behaviour, not a hazard the block resolves.
- Abort: i_abort sampled in RUN/DRAIN flushes the FIFO, o_valid=0 next cycle, → IDLE with no o_done. i_abort in IDLE is ignored.
- Reset mid-command: immediate return to reset values; no o_done.
- Commands arriving while busy are held off by o_cmd_ready=0.

Optional Feature:
- Macro VLS_PERF_CNT_EN.
- Defined: adds output o_stall_cnt[31:0]. It counts cycles where o_valid && !i_ready, saturating at 0xFFFFFFFF. It clears on reset and on each command accept.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- base=0x010, stride=1, len=4, mem[0x10..0x13]=A0..A3, i_ready=1 → o_valid cycles N+2..N+5 carrying A0..A3, o_last only on A3, o_done pulse at N+6.
- base=0xFFE, stride=1, len=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001 and matching data; then stride=0xFFF (-1), base=0x001, len=3 → 0x001, 0x000, 0xFFF.
- len=8 with i_ready toggling 1,0,0,1,… → no beat lost or duplicated, o_data stable while stalled, at most 2 reads ahead of the consumer; with VLS_PERF_CNT_EN, o_stall_cnt equals the number of stalled-valid cycles.
- len=0 → no o_valid, o_done pulses once, o_cmd_ready high again the next cycle.
- i_abort asserted after 3 of 10 beats → o_valid low next cycle, no o_done, o_busy=0; the next command (len=2) streams correctly from its own base.
- i_rst asserted mid-RUN, deasserted, then new command issued → all outputs at reset values during reset; the new stream starts cleanly with no stale FIFO data.
